// File: rtl/mem_port_sequencer.sv
// Load/store sequencer in front of the RAM1/serial-port controller: gates 0xBF00 accesses on UART
// readiness, presents each access for a fixed hold window and returns load data with a strobe.
module mem_port_sequencer #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [15:0] TIMEOUT     = 16'd0,
  parameter logic [15:0] PORT_DATA   = 16'hBF00,
  parameter logic [15:0] PORT_STAT   = 16'hBF01
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  req_read,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        illegal_req,
  output logic        timeout_err,
  output logic [1:0]  memRead,
  output logic [1:0]  memWrite,
  output logic [15:0] ram1Address,
  output logic [15:0] dataIn,
  input  logic [15:0] ctrl_dataOut,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StWaitTx, StWaitRx, StAccess, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_is_read;
  logic [1:0]  r_code;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic [15:0] r_wait_cnt, r_hold_cnt;
  logic        r_rdata_valid, r_illegal, r_timeout_err;

  logic        w_rd_any, w_wr_any, w_valid, w_both;
  logic        w_is_data, w_is_stat, w_tx_ready, w_timeout, w_hold_last;
  logic [15:0] w_wait_inc;

  assign w_rd_any    = |req_read;
  assign w_wr_any    = |req_write;
  assign w_valid     = w_rd_any ^ w_wr_any;
  assign w_both      = w_rd_any & w_wr_any;
  assign w_is_data   = (req_addr == PORT_DATA);
  assign w_is_stat   = (req_addr == PORT_STAT);
  assign w_tx_ready  = tbre & tsre;
  // Saturating wait counter; a zero TIMEOUT disables the abort path entirely.
  assign w_wait_inc  = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
  assign w_timeout   = (TIMEOUT != 16'd0) && (w_wait_inc >= TIMEOUT);
  assign w_hold_last = (r_hold_cnt == HoldLast);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_valid) begin
          if (w_wr_any && w_is_data && !w_tx_ready)                     w_state_next = StWaitTx;
          else if (w_rd_any && w_is_data && !w_is_stat && !data_ready) w_state_next = StWaitRx;
          else                                                          w_state_next = StAccess;
        end
      end
      StWaitTx: begin
        if (w_tx_ready)     w_state_next = StAccess;
        else if (w_timeout) w_state_next = StDone;
      end
      StWaitRx: begin
        if (data_ready)     w_state_next = StAccess;
        else if (w_timeout) w_state_next = StDone;
      end
      StAccess: if (w_hold_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_is_read     <= 1'b0;
      r_code        <= 2'b00;
      r_addr        <= 16'h0000;
      r_wdata       <= 16'h0000;
      r_rdata       <= 16'h0000;
      r_wait_cnt    <= 16'h0000;
      r_hold_cnt    <= 16'h0000;
      r_rdata_valid <= 1'b0;
      r_illegal     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_illegal     <= (r_state == StIdle) && w_both;
      case (r_state)
        StIdle: begin
          if (w_valid) begin
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_is_read  <= w_rd_any;
            r_code     <= w_rd_any ? req_read : req_write;
            r_wait_cnt <= 16'h0000;
            r_hold_cnt <= 16'h0000;
          end
        end
        StWaitTx, StWaitRx: begin
          r_wait_cnt <= w_wait_inc;
          if (w_state_next == StDone) begin
            r_timeout_err <= 1'b1;
            if (r_is_read) begin
              r_rdata       <= 16'h0000;
              r_rdata_valid <= 1'b1;
            end
          end
        end
        StAccess: begin
          r_hold_cnt <= r_hold_cnt + 16'd1;
          if (w_hold_last && r_is_read) begin
            r_rdata       <= ctrl_dataOut;
            r_rdata_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall    = 1'b0;
    memRead  = 2'b00;
    memWrite = 2'b00;
    case (r_state)
      StIdle:             stall = w_valid;
      StWaitTx, StWaitRx: stall = 1'b1;
      StAccess: begin
        stall = 1'b1;
        if (r_is_read) memRead  = r_code;
        else           memWrite = r_code;
      end
      default: ;
    endcase
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign illegal_req = r_illegal;
  assign timeout_err = r_timeout_err;
  assign ram1Address = r_addr;
  assign dataIn      = r_wdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: vector table of single accesses with a load-data scoreboard, plus
// hand sequences for illegal requests, reset during an access and the UART wait timeout.
module tb_mem_port_sequencer;

  localparam int HOLD = 2;

  logic        CLK, RST;
  logic [1:0]  req_read, req_write;
  logic [15:0] req_addr, req_wdata, ctrl_dataOut;
  logic        tbre, tsre, data_ready;

  logic        stall, rdata_valid, illegal_req, timeout_err;
  logic [15:0] rdata, ram1Address, dataIn;
  logic [1:0]  memRead, memWrite;

  logic        to_stall, to_rdata_valid, to_illegal_req, to_timeout_err;
  logic [15:0] to_rdata, to_ram1Address, to_dataIn;
  logic [1:0]  to_memRead, to_memWrite;

  mem_port_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(16'd0)) u_dut (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .illegal_req(illegal_req), .timeout_err(timeout_err), .memRead(memRead),
    .memWrite(memWrite), .ram1Address(ram1Address), .dataIn(dataIn),
    .ctrl_dataOut(ctrl_dataOut), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );

  mem_port_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(16'd4)) u_to (
    .CLK(CLK), .RST(RST), .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .stall(to_stall), .rdata(to_rdata), .rdata_valid(to_rdata_valid),
    .illegal_req(to_illegal_req), .timeout_err(to_timeout_err), .memRead(to_memRead),
    .memWrite(to_memWrite), .ram1Address(to_ram1Address), .dataIn(to_dataIn),
    .ctrl_dataOut(ctrl_dataOut), .tbre(tbre), .tsre(tsre), .data_ready(data_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] dout;
    int          tx_block;   // cycles tbre held low from request cycle
    int          rx_block;   // cycles data_ready held low from request cycle
    int          exp_stall;
  } txn_t;

  txn_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Each strobe must pop exactly one expected load value.
  always @(negedge CLK) begin
    if (!RST && rdata_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: rdata_valid with rdata %0h, none expected", rdata);
      end else begin
        chk("sb_rdata", {16'h0, rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic run_txn(input txn_t t, input string tag);
    int   n_stall, n_acc, n_bad;
    logic done_seen, is_read;
    n_stall = 0; n_acc = 0; n_bad = 0; done_seen = 1'b0;
    is_read = (t.rd != 2'b00);
    if (is_read) exp_q.push_back(t.dout);
    for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
      req_read     = t.rd;
      req_write    = t.wr;
      req_addr     = t.addr;
      req_wdata    = t.wdata;
      ctrl_dataOut = t.dout;
      tbre         = (cyc >= t.tx_block);
      tsre         = 1'b1;
      data_ready   = (cyc >= t.rx_block);
      @(negedge CLK);
      if (stall) n_stall++;
      if (memRead != 2'b00 || memWrite != 2'b00) begin
        n_acc++;
        if (memRead != t.rd || memWrite != t.wr || ram1Address != t.addr ||
            (!is_read && dataIn != t.wdata)) n_bad++;
      end
      if (!stall) begin
        done_seen = 1'b1;
        chk({tag, "_done_valid"}, rdata_valid, is_read);
      end
      step();
    end
    req_read  = 2'b00;
    req_write = 2'b00;
    chk({tag, "_completed"}, done_seen, 1'b1);
    chk({tag, "_stall_cycles"}, n_stall, t.exp_stall);
    chk({tag, "_access_cycles"}, n_acc, HOLD);
    chk({tag, "_bus_bad"}, n_bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int valid_cyc, n_to_rd;
    RST = 1'b1; req_read = 2'b00; req_write = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    ctrl_dataOut = 16'h0; tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;

    vecs[0] = '{2'b00, 2'b01, 16'h4000, 16'h1234, 16'h0000, 0,  0,  3};
    vecs[1] = '{2'b00, 2'b01, 16'hBF00, 16'h0055, 16'h0000, 5,  0,  8};
    vecs[2] = '{2'b01, 2'b00, 16'hBF00, 16'h0000, 16'h0041, 0,  3,  6};
    vecs[3] = '{2'b01, 2'b00, 16'hBF01, 16'h0000, 16'h0003, 0,  99, 3};
    vecs[4] = '{2'b00, 2'b10, 16'h0100, 16'hABCD, 16'h0000, 99, 0,  3};
    vecs[5] = '{2'b11, 2'b00, 16'h1234, 16'h0000, 16'hBEEF, 0,  99, 3};
    vecs[6] = '{2'b00, 2'b10, 16'hBF00, 16'h0042, 16'h0000, 0,  0,  3};

    do_reset();
    @(negedge CLK);
    chk("rst_stall", stall, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_valid", rdata_valid, 1'b0);
    chk("rst_illegal", illegal_req, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    chk("rst_codes", {memRead, memWrite}, 4'b0000);
    chk("rst_addr", ram1Address, 16'h0);
    chk("rst_datain", dataIn, 16'h0);
    step();

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));
    step();

    // Read and write together: dropped, strobe on the following cycle.
    req_read = 2'b01; req_write = 2'b10; req_addr = 16'h3000;
    @(negedge CLK);
    chk("ill_stall", stall, 1'b0);
    chk("ill_codes", {memRead, memWrite}, 4'b0000);
    step();
    req_read = 2'b00; req_write = 2'b00;
    @(negedge CLK);
    chk("ill_pulse", illegal_req, 1'b1);
    chk("ill_stall2", stall, 1'b0);
    step();
    @(negedge CLK);
    chk("ill_pulse_end", illegal_req, 1'b0);
    step();

    // Reset during the first ACCESS cycle.
    req_read = 2'b01; req_addr = 16'h2222; ctrl_dataOut = 16'h5A5A; data_ready = 1'b1;
    @(negedge CLK);
    chk("rma_stall", stall, 1'b1);
    step();
    @(negedge CLK);
    chk("rma_access", memRead, 2'b01);
    RST = 1'b1;
    step();
    RST = 1'b0; req_read = 2'b00;
    @(negedge CLK);
    chk("rma_stall0", stall, 1'b0);
    chk("rma_codes", {memRead, memWrite}, 4'b0000);
    chk("rma_rdata", rdata, 16'h0);
    chk("rma_valid", rdata_valid, 1'b0);
    chk("rma_addr", ram1Address, 16'h0);
    chk("rma_datain", dataIn, 16'h0);
    step();
    @(negedge CLK);
    chk("rma_idle_stall", stall, 1'b0);
    chk("rma_idle_valid", rdata_valid, 1'b0);
    step();

    // Timeout: load a nonzero rdata first so the forced zero is visible.
    do_reset();
    run_txn('{2'b01, 2'b00, 16'h0800, 16'h0000, 16'h7777, 0, 0, 3}, "pre_to");
    chk("pre_to_rdata", to_rdata, 16'h7777);
    valid_cyc = -1; n_to_rd = 0;
    for (int c = 0; c < 16 && valid_cyc < 0; c++) begin
      req_read = 2'b01; req_addr = 16'hBF00; data_ready = 1'b0;
      @(negedge CLK);
      if (to_memRead != 2'b00) n_to_rd++;
      if (to_rdata_valid) begin
        valid_cyc = c;
        chk("to_rdata", to_rdata, 16'h0);
        chk("to_err_set", to_timeout_err, 1'b1);
        chk("to_stall_done", to_stall, 1'b0);
      end
      step();
    end
    req_read = 2'b00;
    chk("to_valid_cycle", valid_cyc, 5);
    chk("to_memread_never", n_to_rd, 0);
    step();
    step();
    @(negedge CLK);
    chk("to_err_sticky", to_timeout_err, 1'b1);
    chk("to_valid_low", to_rdata_valid, 1'b0);
    chk("to_idle_stall", to_stall, 1'b0);
    chk("nto_still_waiting", stall, 1'b1);
    chk("nto_no_err", timeout_err, 1'b0);
    step();

    do_reset();
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
Sits directly upstream of the data-side RAM1/serial-port controller, between the pipeline MEM stage and that controller's memRead/memWrite/ram1Address/dataIn inputs. It accepts one load/store per instruction and stalls the pipeline while a serial access waits for the UART to become ready. It then drives the controller for a fixed hold window and returns load data with a one-cycle valid strobe. Software polling of 0xBF01 remains legal; this block only guarantees that a 0xBF00 access never fires against a busy or empty UART.

Parameters:
HOLD_CYCLES, 2, number of CLK cycles the access is presented to the controller (minimum 1)
TIMEOUT, 16'd0, maximum wait cycles on UART readiness; 0 = wait forever
PORT_DATA, 16'hBF00, serial data address
PORT_STAT, 16'hBF01, serial status address

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous reset, active-high
req_read  in  2  MEM-stage read code; 01/10 = read, 00 = none
req_write  in  2  MEM-stage write code; 01/10 = write, 00 = none
req_addr  in  16  access address
req_wdata  in  16  store data
stall  out  1  freeze pipeline (combinational)
rdata  out  16  load result, registered
rdata_valid  out  1  one-cycle strobe, rdata valid
illegal_req  out  1  one-cycle strobe, read and write requested together
timeout_err  out  1  sticky UART wait timeout flag
memRead  out  2  to controller
memWrite  out  2  to controller
ram1Address  out  16  to controller
dataIn  out  16  to controller
ctrl_dataOut  in  16  controller dataOut
tbre  in  1  UART transmit buffer empty
tsre  in  1  UART shift register empty
data_ready  in  1  UART receive data ready

Behaviour:
- One clock (CLK); synchronous active-high reset RST.
- Reset values: state IDLE, stall 0, rdata 0, rdata_valid 0, illegal_req 0, timeout_err 0, memRead/memWrite 00, ram1Address 0, dataIn 0, counters 0.
- Reset mid-operation aborts with no completion strobe. The controller sees 00 codes from the next edge.
- A request is valid when exactly one of req_read and req_write is nonzero. Code 11 counts as nonzero.
- If both are nonzero: illegal_req pulses one cycle, the request is dropped, and stall stays 0.
- States:
  - IDLE: on a valid request, latch the address, data, direction and original 2-bit code.
    - Write to PORT_DATA with !(tbre&tsre) -> WAIT_TX.
    - Read from PORT_DATA with !data_ready -> WAIT_RX.
    - Otherwise -> ACCESS. This includes PORT_STAT reads and all RAM addresses.
  - WAIT_TX: leave for ACCESS on the first cycle tbre&tsre=1.
  - WAIT_RX: leave for ACCESS on the first cycle data_ready=1.
  - Both WAIT states: wait counter increments each cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT:
    - go to DONE with the access dropped;
    - set timeout_err (sticky until RST);
    - for a read, rdata=0 with rdata_valid=1.
  - ACCESS: drive memRead/memWrite (latched code in the active direction, 00 in the other), ram1Address and dataIn for exactly HOLD_CYCLES cycles.
    - On the last ACCESS cycle, for reads, capture ctrl_dataOut into rdata.
    - Then -> DONE.
  - DONE: one cycle. rdata_valid=1 for reads only. stall=0. Request inputs are ignored because they still belong to the completing instruction. -> IDLE.
- Outside ACCESS, memRead=memWrite=00. ram1Address/dataIn hold their last values, so there are no spurious controller strobes.
- stall = (state in {WAIT_TX, WAIT_RX, ACCESS}) OR (state==IDLE AND valid request).
- stall is 0 in DONE and 0 in IDLE with no request.
- Minimum latency for an unblocked access: request in cycle 0 -> DONE in cycle HOLD_CYCLES+1. stall is high for HOLD_CYCLES+1 cycles.
- UART inputs are sampled only in IDLE and WAIT states. A deassertion during ACCESS does not abort the access.
- TIMEOUT counter width is 16 bits and saturates; no wrap.

Test Plan:
- RAM store: req_write=01, addr=16'h4000, wdata=16'h1234, HOLD_CYCLES=2 -> memWrite=01, ram1Address=4000, dataIn=1234 for cycles 1-2; stall high in cycles 0-2 and low in cycle 3; no rdata_valid.
- Blocked serial write: write to BF00 with tbre=0 for 5 cycles then 1, tsre=1 -> WAIT_TX for 5 cycles, memWrite=00 throughout the wait, then a 2-cycle ACCESS; stall high for 8 cycles in total.
- Serial read: read from BF00 with data_ready rising after 3 cycles, ctrl_dataOut=16'h0041 -> rdata=0041 and rdata_valid high for exactly one cycle, in DONE.
- Status poll: read from BF01 with data_ready=0 -> no wait state; rdata=ctrl_dataOut after HOLD_CYCLES+1 cycles.
- Timeout: TIMEOUT=4, read from BF00 with data_ready held 0 -> after 4 wait cycles rdata=0 with rdata_valid=1, timeout_err=1 and staying set; memRead is never nonzero.
- Illegal request and reset: req_read=01 with req_write=10 -> illegal_req pulse, stall 0. Separately, RST asserted mid-ACCESS -> next cycle all outputs at reset values and state IDLE.
